// File: rtl/probe_mon_pkg.sv
// Shared types for the AXI4-Lite probe monitor: record encoding, field widths
// and the packed record layout carried through the record FIFO.
package probe_mon_pkg;

  localparam int ID_W    = 12;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int BEATS_W = 4;

  typedef enum logic {
    REC_WRITE = 1'b0,
    REC_READ  = 1'b1
  } rec_type_e;

  typedef struct packed {
    rec_type_e           rec_type;
    logic [ID_W-1:0]     id;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [STRB_W-1:0]   strb;
    logic [BEATS_W-1:0]  beats;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/probe_rec_fifo.sv
// Synchronous show-ahead FIFO; the head entry is presented while not empty and
// reads as zero when empty so the record outputs are quiet after reset.
module probe_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/axi4_lite_probe_monitor.sv
// Passive AXI4-Lite transaction monitor: rebuilds one write and one read at a
// time from probe taps, stamps address-to-response latency, queues records.
module axi4_lite_probe_monitor
  import probe_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LAT_W      = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               en,
  input  logic [11:0]        p_axi_awid,
  input  logic [31:0]        p_axi_awaddr,
  input  logic               p_axi_awvalid,
  input  logic               p_axi_awready,
  input  logic [3:0]         p_axi_wstrb,
  input  logic [31:0]        p_axi_wdata,
  input  logic               p_axi_wvalid,
  input  logic               p_axi_wready,
  input  logic [11:0]        p_axi_bid,
  input  logic               p_axi_bvalid,
  input  logic               p_axi_bready,
  input  logic [11:0]        p_axi_arid,
  input  logic [31:0]        p_axi_araddr,
  input  logic               p_axi_arvalid,
  input  logic               p_axi_arready,
  input  logic [11:0]        p_axi_rid,
  input  logic               p_axi_rlast,
  input  logic [31:0]        p_axi_rdata,
  input  logic               p_axi_rvalid,
  input  logic               p_axi_rready,
  output logic               m_rec_valid,
  input  logic               m_rec_ready,
  output logic               m_rec_type,
  output logic [11:0]        m_rec_id,
  output logic [31:0]        m_rec_addr,
  output logic [31:0]        m_rec_data,
  output logic [3:0]         m_rec_strb,
  output logic [3:0]         m_rec_beats,
  output logic [LAT_W-1:0]   m_rec_lat,
  output logic [31:0]        wr_count,
  output logic [31:0]        rd_count,
  output logic [15:0]        drop_count,
  output logic               proto_err
);
  localparam int ENT_W = REC_W + LAT_W;

  function automatic logic [LAT_W-1:0] lat_sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  function automatic logic [BEATS_W-1:0] beats_sat_inc(input logic [BEATS_W-1:0] v);
    return (&v) ? v : v + BEATS_W'(1);
  endfunction

  function automatic logic [15:0] drop_sat_add(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  assign aw_hs = en & p_axi_awvalid & p_axi_awready;
  assign w_hs  = en & p_axi_wvalid & p_axi_wready;
  assign ar_hs = en & p_axi_arvalid & p_axi_arready;
  assign b_hs  = p_axi_bvalid & p_axi_bready;
  assign r_hs  = p_axi_rvalid & p_axi_rready;

  logic                aw_done, w_done, ar_pend;
  logic [ID_W-1:0]     wr_id, rd_id;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [BEATS_W-1:0]  rd_beats;
  logic [LAT_W-1:0]    wr_lat, rd_lat;

  logic b_full, b_id_ok, r_id_ok, wr_done_ok, rd_done_ok, viol;
  assign b_full     = aw_done & w_done;
  assign b_id_ok    = (p_axi_bid == wr_id);
  assign r_id_ok    = (p_axi_rid == rd_id);
  assign wr_done_ok = b_hs & b_full & b_id_ok;
  assign rd_done_ok = r_hs & ar_pend & r_id_ok & p_axi_rlast;
  assign viol = (aw_hs & aw_done) | (w_hs & w_done) | (ar_hs & ar_pend)
              | (b_hs & ~(b_full & b_id_ok)) | (r_hs & ~(ar_pend & r_id_ok));

  rec_t wr_rec, rd_rec;
  always_comb begin
    wr_rec          = '0;
    wr_rec.rec_type = REC_WRITE;
    wr_rec.id       = wr_id;
    wr_rec.addr     = wr_addr;
    wr_rec.data     = wr_data;
    wr_rec.strb     = wr_strb;
    rd_rec          = '0;
    rd_rec.rec_type = REC_READ;
    rd_rec.id       = rd_id;
    rd_rec.addr     = rd_addr;
    rd_rec.data     = p_axi_rdata;
    rd_rec.beats    = rd_beats;
  end

  logic [ENT_W-1:0] wr_stage_p1, rd_stage_p1, push_data, fifo_dout;
  logic             vld_wr_p1, vld_rd_p1;
  logic             fifo_full, fifo_empty, pop, can_push, push_wr, push_rd, push;
  logic             wr_take, rd_take;
  logic [1:0]       drops;

  // Write stage has priority for the single push slot; a stage frees as it pushes
  assign pop       = ~fifo_empty & m_rec_ready;
  assign can_push  = ~fifo_full | pop;
  assign push_wr   = vld_wr_p1 & can_push;
  assign push_rd   = vld_rd_p1 & ~vld_wr_p1 & can_push;
  assign push      = push_wr | push_rd;
  assign push_data = push_wr ? wr_stage_p1 : rd_stage_p1;
  assign wr_take   = wr_done_ok & (~vld_wr_p1 | push_wr);
  assign rd_take   = rd_done_ok & (~vld_rd_p1 | push_rd);
  assign drops     = {1'b0, wr_done_ok & ~wr_take} + {1'b0, rd_done_ok & ~rd_take};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      ar_pend    <= 1'b0;
      vld_wr_p1  <= 1'b0;
      vld_rd_p1  <= 1'b0;
      wr_count   <= '0;
      rd_count   <= '0;
      drop_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (aw_hs && !aw_done)   aw_done <= 1'b1;
      else if (b_hs && b_full) aw_done <= 1'b0;
      if (w_hs && !w_done)     w_done <= 1'b1;
      else if (b_hs && b_full) w_done <= 1'b0;
      if (ar_hs && !ar_pend)   ar_pend <= 1'b1;
      else if (r_hs && ar_pend && (p_axi_rlast || !r_id_ok)) ar_pend <= 1'b0;
      if (wr_take)      vld_wr_p1 <= 1'b1;
      else if (push_wr) vld_wr_p1 <= 1'b0;
      if (rd_take)      vld_rd_p1 <= 1'b1;
      else if (push_rd) vld_rd_p1 <= 1'b0;
      wr_count   <= wr_count + 32'(push_wr);
      rd_count   <= rd_count + 32'(push_rd);
      drop_count <= drop_sat_add(drop_count, drops);
      proto_err  <= proto_err | viol;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs && !aw_done) begin
      wr_id   <= p_axi_awid;
      wr_addr <= p_axi_awaddr;
      wr_lat  <= LAT_W'(1);
    end else if (aw_done) begin
      wr_lat  <= lat_sat_inc(wr_lat);
    end
    if (w_hs && !w_done) begin
      wr_data <= p_axi_wdata;
      wr_strb <= p_axi_wstrb;
    end
    if (ar_hs && !ar_pend) begin
      rd_id    <= p_axi_arid;
      rd_addr  <= p_axi_araddr;
      rd_lat   <= LAT_W'(1);
      rd_beats <= '0;
    end else if (ar_pend) begin
      rd_lat   <= lat_sat_inc(rd_lat);
      if (r_hs) rd_beats <= beats_sat_inc(rd_beats);
    end
    if (wr_take) wr_stage_p1 <= {wr_rec, wr_lat};
    if (rd_take) rd_stage_p1 <= {rd_rec, rd_lat};
  end

  probe_rec_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  rec_t out_rec;
  assign out_rec     = fifo_dout[ENT_W-1:LAT_W];
  assign m_rec_valid = ~fifo_empty;
  assign m_rec_type  = out_rec.rec_type;
  assign m_rec_id    = out_rec.id;
  assign m_rec_addr  = out_rec.addr;
  assign m_rec_data  = out_rec.data;
  assign m_rec_strb  = out_rec.strb;
  assign m_rec_beats = out_rec.beats;
  assign m_rec_lat   = fifo_dout[LAT_W-1:0];

endmodule
